// File: rtl/upsampler_if.sv
// Purpose: sample-in / interpolated-word-out bundle of the 16x upsampler.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side; the output side is valid-only.
// Ports: in_valid/in_ready/in_data (12-bit offset-binary sample),
//        out_valid/out (48-bit signed word), seg_start, underrun.
interface upsampler_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic [47:0] out;
  logic        seg_start;
  logic        underrun;

  // master: the sample source / output consumer
  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out, seg_start, underrun
  );

  // slave: the upsampler itself
  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out, seg_start, underrun
  );
endinterface

// File: rtl/upsampler.sv
// Purpose: 16x linear-interpolating upsampler, 12-bit offset-binary in, 48-bit signed out.
// Latency: first two samples accepted on cycles t, t+1 -> out_valid at t+3 with out = X(first).
// Backpressure: 4-entry FIFO; in_ready = FIFO not full; one sample consumed per 16 cycles.
// Ports: adc_clk, nreset (async, active-low), bus (upsampler_if.slave).
//   The sample MSB lands on bit RANGE_H of the 48-bit word (legal 15..46).
module upsampler #(
  parameter int RANGE_H = 28
) (
  input  logic       adc_clk,
  input  logic       nreset,
  upsampler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD1, RUN, HOLD} state_t;

  state_t      state, state_nxt;

  logic [11:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        push, pop, have;

  logic [47:0] target, acc, step;
  logic [3:0]  phase;
  logic        underrun_q;

  logic        take_first, seg_load, hold_enter;
  logic [47:0] x_pop, step_new;
  logic signed [47:0] diff;

  // Offset-binary -> signed, sign-extended above RANGE_H, zero-filled below.
  // At least 4 zero LSBs guarantee the >>> 4 below is exact.
  function automatic logic [47:0] to_x(input logic [11:0] d);
    logic [11:0] s;
    s = d ^ 12'h800;
    return {{(47 - RANGE_H){s[11]}}, s, {(RANGE_H - 11){1'b0}}};
  endfunction

  assign have     = (count != 3'd0);
  assign push     = bus.in_valid && bus.in_ready;
  assign x_pop    = to_x(mem[rd_ptr]);
  assign diff     = $signed(x_pop) - $signed(target);
  assign step_new = diff >>> 4;

  assign bus.in_ready = (count != 3'd4);
  assign bus.out      = acc;
  assign bus.underrun = underrun_q;

  // FIFO: registered count, push and pop may coincide.
  always_ff @(posedge adc_clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  // FSM: state register
  always_ff @(posedge adc_clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (have) state_nxt = LOAD1;
      LOAD1:   if (have) state_nxt = RUN;
      RUN:     if (phase == 4'hf && !have) state_nxt = HOLD;
      HOLD:    if (have) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    take_first    = 1'b0;
    seg_load      = 1'b0;
    hold_enter    = 1'b0;
    bus.out_valid = 1'b0;
    bus.seg_start = 1'b0;
    case (state)
      IDLE:  take_first = have;
      LOAD1: seg_load = have;
      RUN: begin
        bus.out_valid = 1'b1;
        bus.seg_start = (phase == 4'h0);
        if (phase == 4'hf) begin
          seg_load   = have;
          hold_enter = !have;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        seg_load      = have;
      end
      default: ;
    endcase
    pop = take_first || seg_load;
  end

  // Datapath. The segment base is only needed at load time, where it equals
  // the outgoing target; acc carries it from then on, so no separate base reg.
  always_ff @(posedge adc_clk or negedge nreset) begin
    if (!nreset) begin
      target     <= '0;
      acc        <= '0;
      step       <= '0;
      phase      <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= hold_enter;
      if (take_first) begin
        target <= x_pop;
      end else if (seg_load) begin
        target <= x_pop;
        acc    <= target;
        step   <= step_new;
        phase  <= '0;
      end else if (hold_enter) begin
        acc   <= target;
        step  <= '0;
        phase <= phase + 4'd1;
      end else if (state == RUN) begin
        acc   <= acc + step;
        phase <= phase + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_upsampler.sv
// Purpose: randomized + directed bench for upsampler with a segment-level scoreboard.
// Latency: n/a.
// Backpressure: drives in_valid and waits on in_ready with a bounded wait.
module tb_upsampler;
  localparam int RANGE_H = 28;

  logic adc_clk = 1'b0;
  logic nreset  = 1'b0;

  upsampler_if bus();

  upsampler #(.RANGE_H(RANGE_H)) dut (
    .adc_clk (adc_clk),
    .nreset  (nreset),
    .bus     (bus)
  );

  always #5 adc_clk = ~adc_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference value of a sample: signed sample times 2^(RANGE_H-11).
  function automatic longint xval(input logic [11:0] d);
    logic signed [11:0] s;
    s = d ^ 12'h800;
    return longint'(s) * (longint'(1) << (RANGE_H - 11));
  endfunction

  typedef struct {
    longint base;
    longint target;
  } seg_t;

  seg_t   segq[$];
  logic   have_prev = 1'b0;
  longint prev_x    = 0;

  // Acceptor: every handshake extends the expected stream by one segment
  // (previous sample -> this sample).
  always @(negedge adc_clk) begin
    longint x;
    if (!nreset) begin
      segq.delete();
      have_prev = 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      x = xval(bus.in_data);
      if (have_prev) segq.push_back('{prev_x, x});
      prev_x    = x;
      have_prev = 1'b1;
    end
  end

  // Monitor: expected out = base + k*(target-base)/16 for k = 0..15, then the
  // held target for any cycles until the next seg_start.
  int     k  = -1;
  longint cb = 0, ct = 0, cs = 0;

  always @(negedge adc_clk) begin
    seg_t   s;
    longint e;
    if (!nreset) begin
      k = -1;
    end else if (bus.out_valid) begin
      if (bus.seg_start) begin
        if (k >= 0) chk("seg_len", 64'(k >= 16), 64'(1));
        if (segq.size() == 0) begin
          chk("seg_expected", 64'(0), 64'(1));
          k = -1;
        end else begin
          s  = segq.pop_front();
          cb = s.base;
          ct = s.target;
          cs = (ct - cb) / 16;
          k  = 0;
        end
      end
      if (k < 0) begin
        chk("out_without_segment", 64'(0), 64'(1));
      end else begin
        e = (k < 16) ? cb + longint'(k) * cs : ct;
        chk("out", {16'h0, bus.out}, {16'h0, 48'(e)});
        chk("underrun", 64'(bus.underrun), 64'(k == 16));
        if (k < 1000) k++;
      end
    end
  end

  task automatic push(input logic [11:0] d, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waited = 0;
    do begin
      @(negedge adc_clk);
      waited++;
    end while (!bus.in_ready && waited < 200);
    if (!bus.in_ready) chk("push_timeout", 64'(waited), 64'(0));
    @(posedge adc_clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge adc_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    nreset = 1'b0;
    cycles(3);
    nreset = 1'b1;
  endtask

  // Ramp: 0x800 then a steady stream of 0xC00.
  task automatic ramp(input string tag);
    int w;
    push(12'h800, w);
    push(12'hC00, w);
    @(negedge adc_clk);
    chk({tag, "_lat_t2_valid"}, 64'(bus.out_valid), 64'(0));
    @(negedge adc_clk);
    chk({tag, "_lat_t3_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_p0_out"}, {16'h0, bus.out}, 64'h0);
    chk({tag, "_p0_seg_start"}, 64'(bus.seg_start), 64'(1));
    repeat (14) @(negedge adc_clk);
    @(negedge adc_clk);
    chk({tag, "_p15_out"}, {16'h0, bus.out}, 64'h0780_0000);
    @(negedge adc_clk);
    chk({tag, "_next_out"}, {16'h0, bus.out}, 64'h0800_0000);
    chk({tag, "_next_seg_start"}, 64'(bus.seg_start), 64'(1));
    @(posedge adc_clk);
    #1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [47:0] held;
    bus.in_valid = 1'b0;
    bus.in_data  = 12'h0;

    // Reset values
    cycles(3);
    @(negedge adc_clk);
    chk("rst_out", {16'h0, bus.out}, 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_underrun", 64'(bus.underrun), 64'(0));
    chk("rst_seg_start", 64'(bus.seg_start), 64'(0));
    @(posedge adc_clk);
    #1;
    nreset = 1'b1;
    @(negedge adc_clk);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
    cycles(1);

    ramp("ramp");
    cycles(20);

    // Negative step, then underrun, hold, resume
    do_reset();
    push(12'h800, w);
    push(12'h000, w);
    idle();
    @(negedge adc_clk);
    @(negedge adc_clk);
    chk("neg_p0_out", {16'h0, bus.out}, 64'h0);
    repeat (14) @(negedge adc_clk);
    @(negedge adc_clk);
    chk("neg_p15_out", {16'h0, bus.out}, 64'hFFFF_F100_0000);
    @(negedge adc_clk);
    chk("neg_next_out", {16'h0, bus.out}, 64'hFFFF_F000_0000);
    chk("neg_underrun_pulse", 64'(bus.underrun), 64'(1));
    chk("neg_hold_no_seg_start", 64'(bus.seg_start), 64'(0));
    held = bus.out;
    cycles(40);
    @(negedge adc_clk);
    chk("hold_out_const", {16'h0, bus.out}, 64'hFFFF_F000_0000);
    chk("hold_underrun_low", 64'(bus.underrun), 64'(0));
    @(posedge adc_clk);
    #1;
    push(12'h800, w);
    idle();
    @(negedge adc_clk);
    chk("resume_wait_seg_start", 64'(bus.seg_start), 64'(0));
    @(negedge adc_clk);
    chk("resume_seg_start", 64'(bus.seg_start), 64'(1));
    chk("resume_out_held", {16'h0, bus.out}, {16'h0, held});
    cycles(20);

    // Backpressure: in_valid held high with distinct samples
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push(12'(i * 331 + 17), w);
      if (i >= 8) chk("bp_accept_gap", 64'(w), 64'(16));
    end
    idle();
    @(negedge adc_clk);
    chk("bp_full_in_ready", 64'(bus.in_ready), 64'(0));
    cycles(110);
    chk("bp_drained", 64'(segq.size()), 64'(0));

    // Mid-run reset at phase 7 with 3 words queued
    do_reset();
    push(12'h800, w);
    for (int i = 0; i < 4; i++) push(12'hC00, w);
    idle();
    @(negedge adc_clk);
    repeat (5) @(negedge adc_clk);
    chk("mid_p7_out", {16'h0, bus.out}, 64'h0380_0000);
    #1;
    nreset = 1'b0;
    #1;
    chk("mid_rst_out", {16'h0, bus.out}, 64'h0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_seg_start", 64'(bus.seg_start), 64'(0));
    chk("mid_rst_underrun", 64'(bus.underrun), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    cycles(3);
    nreset = 1'b1;
    ramp("mid_ramp");
    cycles(40);

    // Random samples with random gaps (some long enough to underrun)
    do_reset();
    for (int i = 0; i < 30; i++) begin
      push(12'($urandom_range(0, 4095)), w);
      idle();
      cycles($urandom_range(0, 24));
    end
    cycles(120);
    chk("rand_drained", 64'(segq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
